// File: rtl/fnd_scan_ctrl.sv
// fnd_scan_ctrl
//   N-digit multiplexed 7-segment scan controller. Snapshots the digit codes
//   and masks once per frame, scans one digit at a time onto a shared segment
//   bus, keeps all commons off for a few cycles after each switch to avoid
//   ghosting, and supports leading-zero suppression and a hex glyph mode.
//
// Ports
//   clk         system clock, rising edge
//   reset       synchronous active-high reset
//   digit_in    packed 4-bit codes, digit i at [4i+3:4i], digit 0 rightmost
//   dp_in       per-digit decimal point request
//   blank_in    per-digit forced blank
//   lz_en       leading-zero suppression enable
//   hex_mode    1: A-F render as hex letters; 0: A-D dash, E blank, F dp-only
//   fnd_com     one-hot digit select (active-low when ACTIVE_LOW=1)
//   fnd_data    {dp,g,f,e,d,c,b,a} (active-low when ACTIVE_LOW=1)
//   frame_tick  one-cycle pulse in the first cycle a new snapshot is shown
module fnd_scan_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int CLK_HZ     = 100_000_000,
    parameter int SCAN_HZ    = 1000,
    parameter int BLANK_CYC  = 2,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digit_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic                    lz_en,
    input  logic                    hex_mode,
    output logic [NUM_DIGITS-1:0]   fnd_com,
    output logic [7:0]              fnd_data,
    output logic                    frame_tick
);

    localparam int DIV = CLK_HZ / SCAN_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW  = $clog2(NUM_DIGITS);
    localparam int BW  = $clog2(BLANK_CYC + 1) + 1;

    localparam logic [PW-1:0]         PSC_LAST   = PW'(DIV - 1);
    localparam logic [IW-1:0]         IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [BW-1:0]         BLANK_LOAD = BW'(BLANK_CYC);
    localparam logic [NUM_DIGITS-1:0] COM_OFF    = (ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [7:0]            DATA_OFF   = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

    generate
        if (DIV < BLANK_CYC + 2) begin : g_bad_div
            $error("fnd_scan_ctrl: CLK_HZ/SCAN_HZ must be >= BLANK_CYC+2");
        end
        if (NUM_DIGITS < 2 || NUM_DIGITS > 8) begin : g_bad_digits
            $error("fnd_scan_ctrl: NUM_DIGITS must be in 2..8");
        end
    endgenerate

    logic [PW-1:0]           psc_reg;
    logic [IW-1:0]           idx_reg;
    logic [BW-1:0]           bcnt_reg;
    logic                    load_pending_reg;
    logic [4*NUM_DIGITS-1:0] sh_digit_reg;
    logic [NUM_DIGITS-1:0]   sh_dp_reg;
    logic [NUM_DIGITS-1:0]   sh_blank_reg;
    logic                    sh_lz_reg;
    logic                    sh_hex_reg;
    logic                    wrap_reg;
    logic                    frame_tick_reg;
    logic [NUM_DIGITS-1:0]   com_reg;
    logic [7:0]              data_reg;

    logic                    tick;
    logic                    wrap;
    logic [NUM_DIGITS-1:0]   is_zero;
    logic [NUM_DIGITS-1:0]   supp_vec;
    logic                    lz_run;
    logic [3:0]              cur_code;
    logic                    cur_supp;
    logic [7:0]              glyph_al;
    logic [NUM_DIGITS-1:0]   onehot;
    logic [NUM_DIGITS-1:0]   com_next;
    logic [7:0]              data_next;

    assign tick = (psc_reg == PSC_LAST);
    assign wrap = tick && (idx_reg == IDX_LAST);

    // A digit is a suppression candidate when it shows a plain zero.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_zero
            assign is_zero[gi] = (sh_digit_reg[4*gi +: 4] == 4'd0) && !sh_dp_reg[gi];
        end
    endgenerate

    // Suppression runs from the top digit down and stops at the first
    // non-candidate; digit 0 is never part of the run.
    always_comb begin
        supp_vec = '0;
        lz_run   = sh_lz_reg;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            lz_run      = lz_run && is_zero[i];
            supp_vec[i] = lz_run;
        end
    end

    // Active-low glyph table, bit7 = dp.
    function automatic logic [7:0] glyph(input logic [3:0] code, input logic hex);
        logic [7:0] g;
        case (code)
            4'h0:    g = 8'hC0;
            4'h1:    g = 8'hF9;
            4'h2:    g = 8'hA4;
            4'h3:    g = 8'hB0;
            4'h4:    g = 8'h99;
            4'h5:    g = 8'h92;
            4'h6:    g = 8'h82;
            4'h7:    g = 8'hF8;
            4'h8:    g = 8'h80;
            4'h9:    g = 8'h90;
            4'hA:    g = hex ? 8'h88 : 8'hBF;
            4'hB:    g = hex ? 8'h83 : 8'hBF;
            4'hC:    g = hex ? 8'hC6 : 8'hBF;
            4'hD:    g = hex ? 8'hA1 : 8'hBF;
            4'hE:    g = hex ? 8'h86 : 8'hFF;
            default: g = hex ? 8'h8E : 8'h7F;
        endcase
        return g;
    endfunction

    always_comb begin
        cur_code = sh_digit_reg[4*idx_reg +: 4];
        cur_supp = supp_vec[idx_reg];
        glyph_al = 8'hFF;
        if (!(sh_blank_reg[idx_reg] || cur_supp)) begin
            glyph_al = glyph(cur_code, sh_hex_reg);
        end
        if (sh_dp_reg[idx_reg]) begin
            glyph_al[7] = 1'b0;
        end

        onehot          = '0;
        onehot[idx_reg] = 1'b1;

        // Commons stay dark while the blanking counter runs; the segment
        // bus already carries the new digit so it settles before lighting.
        com_next  = (bcnt_reg != '0) ? COM_OFF : (COM_OFF ^ onehot);
        data_next = (ACTIVE_LOW != 0) ? glyph_al : ~glyph_al;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            psc_reg          <= '0;
            idx_reg          <= '0;
            bcnt_reg         <= BLANK_LOAD;
            load_pending_reg <= 1'b1;
            sh_digit_reg     <= '0;
            sh_dp_reg        <= '0;
            sh_blank_reg     <= '0;
            sh_lz_reg        <= 1'b0;
            sh_hex_reg       <= 1'b0;
            wrap_reg         <= 1'b0;
            frame_tick_reg   <= 1'b0;
            com_reg          <= COM_OFF;
            data_reg         <= DATA_OFF;
        end else begin
            psc_reg <= tick ? '0 : psc_reg + 1'b1;
            if (tick) begin
                idx_reg <= wrap ? '0 : idx_reg + 1'b1;
            end
            if (tick) begin
                bcnt_reg <= BLANK_LOAD;
            end else if (bcnt_reg != '0) begin
                bcnt_reg <= bcnt_reg - 1'b1;
            end

            load_pending_reg <= 1'b0;
            if (load_pending_reg || wrap) begin
                sh_digit_reg <= digit_in;
                sh_dp_reg    <= dp_in;
                sh_blank_reg <= blank_in;
                sh_lz_reg    <= lz_en;
                sh_hex_reg   <= hex_mode;
            end

            // Delayed one extra cycle so the pulse lines up with the first
            // output cycle rendered from the freshly loaded snapshot.
            wrap_reg       <= wrap;
            frame_tick_reg <= wrap_reg;

            com_reg  <= com_next;
            data_reg <= data_next;
        end
    end

    assign fnd_com    = com_reg;
    assign fnd_data   = data_reg;
    assign frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
module tb_fnd_scan_ctrl;

    localparam int ND    = 4;
    localparam int DIV   = 10;
    localparam int BLANK = 2;

    logic          clk;
    logic          reset;
    logic [15:0]   digit_in;
    logic [3:0]    dp_in;
    logic [3:0]    blank_in;
    logic          lz_en;
    logic          hex_mode;
    logic [3:0]    fnd_com;
    logic [7:0]    fnd_data;
    logic          frame_tick;

    fnd_scan_ctrl #(
        .NUM_DIGITS(ND),
        .CLK_HZ    (1000),
        .SCAN_HZ   (100),
        .BLANK_CYC (BLANK),
        .ACTIVE_LOW(1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .digit_in  (digit_in),
        .dp_in     (dp_in),
        .blank_in  (blank_in),
        .lz_en     (lz_en),
        .hex_mode  (hex_mode),
        .fnd_com   (fnd_com),
        .fnd_data  (fnd_data),
        .frame_tick(frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] com;
        logic [7:0] data;
    } exp_t;

    typedef struct {
        logic [15:0] digit;
        logic [3:0]  dp;
        logic [3:0]  blank;
        logic        lz;
        logic        hex;
        logic [31:0] exp;   // expected glyph of digit i at [8i+7:8i]
    } vec_t;

    exp_t sb[$];
    vec_t vecs[12];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Wait (bounded) until frame_tick is high at a negedge sample point.
    task automatic wait_frame();
        int g;
        g = 0;
        while (frame_tick !== 1'b1 && g < 100) begin
            @(negedge clk);
            g++;
        end
        chk("frame_tick_seen", {31'd0, frame_tick}, 32'd1);
    endtask

    task automatic wait_com(input logic [3:0] want);
        int g;
        g = 0;
        while (fnd_com !== want && g < 100) begin
            @(negedge clk);
            g++;
        end
        chk("com_reached", {28'd0, fnd_com}, {28'd0, want});
    endtask

    // Called in the frame_tick cycle; consumes ND scoreboard entries.
    task automatic check_frame();
        exp_t e;
        int   off;
        int   on;
        for (int d = 0; d < ND; d++) begin
            if (sb.size() == 0) begin
                chk("sb_empty", 32'd0, 32'd1);
                return;
            end
            e = sb.pop_front();
            chk($sformatf("data_at_switch_d%0d", d), {24'd0, fnd_data}, {24'd0, e.data});
            off = 0;
            while (fnd_com === 4'hF && off < DIV) begin
                off++;
                @(negedge clk);
            end
            chk($sformatf("blank_cycles_d%0d", d), off, BLANK);
            chk($sformatf("com_d%0d", d), {28'd0, fnd_com}, {28'd0, e.com});
            chk($sformatf("data_d%0d", d), {24'd0, fnd_data}, {24'd0, e.data});
            on = 0;
            while (fnd_com === e.com && on < DIV + 2) begin
                on++;
                @(negedge clk);
            end
            chk($sformatf("active_cycles_d%0d", d), on, DIV - BLANK);
            $display("digit %0d com=%h data=%h off=%0d on=%0d", d, e.com, e.data, off, on);
        end
    endtask

    task automatic push_frame(input logic [31:0] exp);
        exp_t e;
        for (int d = 0; d < ND; d++) begin
            e.com  = ~(4'b0001 << d);
            e.data = exp[8*d +: 8];
            sb.push_back(e);
        end
    endtask

    task automatic apply_vec(input vec_t v);
        wait_frame();
        digit_in = v.digit;
        dp_in    = v.dp;
        blank_in = v.blank;
        lz_en    = v.lz;
        hex_mode = v.hex;
        push_frame(v.exp);
        @(negedge clk);
        wait_frame();
        $display("vector digit=%h dp=%b blank=%b lz=%b hex=%b exp=%h",
                 v.digit, v.dp, v.blank, v.lz, v.hex, v.exp);
        check_frame();
    endtask

    initial begin
        int n;
        int first_ft;

        vecs[0]  = '{16'h1234, 4'b0000, 4'b0000, 1'b0, 1'b0, 32'hF9A4B099};
        vecs[1]  = '{16'h0070, 4'b0000, 4'b0000, 1'b1, 1'b0, 32'hFFFFF8C0};
        vecs[2]  = '{16'h0070, 4'b1000, 4'b0000, 1'b1, 1'b0, 32'h40C0F8C0};
        vecs[3]  = '{16'hABEF, 4'b0000, 4'b0000, 1'b0, 1'b1, 32'h8883868E};
        vecs[4]  = '{16'hABEF, 4'b0000, 4'b0000, 1'b0, 1'b0, 32'hBFBFFF7F};
        vecs[5]  = '{16'hABEF, 4'b0000, 4'b0001, 1'b0, 1'b0, 32'hBFBFFFFF};
        vecs[6]  = '{16'h0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 32'hFFFFFFC0};
        vecs[7]  = '{16'h5678, 4'b0101, 4'b0010, 1'b0, 1'b0, 32'h9202FF00};
        vecs[8]  = '{16'h9000, 4'b0000, 4'b0000, 1'b1, 1'b0, 32'h90C0C0C0};
        vecs[9]  = '{16'h0C00, 4'b0000, 4'b0000, 1'b1, 1'b0, 32'hFFBFC0C0};
        vecs[10] = '{16'h1111, 4'b0010, 4'b1111, 1'b0, 1'b0, 32'hFFFF7FFF};
        vecs[11] = '{16'h0000, 4'b0001, 4'b0000, 1'b1, 1'b0, 32'hFFFFFF40};

        // Reset: held three cycles, inputs already showing 1234.
        reset    = 1'b1;
        digit_in = 16'h1234;
        dp_in    = 4'b0000;
        blank_in = 4'b0000;
        lz_en    = 1'b0;
        hex_mode = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_com", {28'd0, fnd_com}, 32'hF);
            chk("reset_data", {24'd0, fnd_data}, 32'hFF);
            chk("reset_ft", {31'd0, frame_tick}, 32'd0);
            $display("reset cycle %0d com=%h data=%h ft=%b", i, fnd_com, fnd_data, frame_tick);
        end
        reset = 1'b0;

        // n counts rising edges since release, sampled at the following negedge.
        n        = 0;
        first_ft = -1;
        while (first_ft < 0 && n < 80) begin
            @(negedge clk);
            n++;
            if (frame_tick === 1'b1) first_ft = n;
            if (n == 1) begin
                chk("post_rst_data_cleared", {24'd0, fnd_data}, 32'hC0);
                chk("post_rst_com1", {28'd0, fnd_com}, 32'hF);
            end
            if (n == 2) begin
                chk("post_rst_data_loaded", {24'd0, fnd_data}, 32'h99);
                chk("post_rst_com2", {28'd0, fnd_com}, 32'hF);
            end
            if (n == 3)  chk("post_rst_d0_on", {28'd0, fnd_com}, 32'hE);
            if (n == 10) chk("pre_tick_com", {28'd0, fnd_com}, 32'hE);
            if (n == 11) begin
                chk("first_tick_data", {24'd0, fnd_data}, 32'hB0);
                chk("first_tick_blank", {28'd0, fnd_com}, 32'hF);
            end
            if (n == 13) chk("first_tick_d1_on", {28'd0, fnd_com}, 32'hD);
        end
        chk("first_frame_tick_edge", first_ft, ND * DIV + 1);
        $display("first frame_tick at edge %0d after release", first_ft);

        // Frame period: from this frame_tick to the next.
        @(negedge clk);
        n = 1;
        while (frame_tick !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("frame_period", n, ND * DIV);
        $display("frame period %0d cycles", n);

        for (int v = 0; v < 12; v++) begin
            apply_vec(vecs[v]);
        end

        // Snapshot: change input while digit 1 is lit.
        apply_vec('{16'h1111, 4'b0000, 4'b0000, 1'b0, 1'b0, 32'hF9F9F9F9});
        wait_com(4'hD);
        digit_in = 16'h2222;
        n = 0;
        while (frame_tick !== 1'b1 && n < 60) begin
            if (fnd_com !== 4'hF) chk("snap_old_data", {24'd0, fnd_data}, 32'hF9);
            @(negedge clk);
            n++;
        end
        chk("snap_ft", {31'd0, frame_tick}, 32'd1);
        chk("snap_new_at_tick", {24'd0, fnd_data}, 32'hA4);
        $display("snapshot switched to 2222 at frame_tick");
        push_frame(32'hA4A4A4A4);
        check_frame();

        // Reset mid-frame while digit 2 is lit.
        wait_com(4'hB);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_com", {28'd0, fnd_com}, 32'hF);
        chk("midrst_data", {24'd0, fnd_data}, 32'hFF);
        chk("midrst_ft", {31'd0, frame_tick}, 32'd0);
        reset = 1'b0;
        n        = 0;
        first_ft = -1;
        while (first_ft < 0 && n < 80) begin
            @(negedge clk);
            n++;
            if (frame_tick === 1'b1) first_ft = n;
        end
        chk("midrst_next_ft_edge", first_ft, ND * DIV + 1);
        $display("mid-frame reset: next frame_tick at edge %0d", first_ft);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
